// File: rtl/fft_addr_sequencer.sv
// Address/twiddle sequencer for an in-place radix-2 FFT.
// One start pulse walks every butterfly of every stage and streams the beats out under valid/ready.
module fft_addr_sequencer #(
    parameter int LOG2_N    = 10,
    parameter int STAGE_GAP = 2,
    localparam int CW       = LOG2_N - 1,
    localparam int SW       = $clog2(LOG2_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              inverse,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [LOG2_N-1:0] indexA,
    output logic [LOG2_N-1:0] indexB,
    output logic [CW-1:0]     twiddleIndex,
    output logic              twiddleConj,
    output logic [SW-1:0]     stage,
    output logic              lastBeat,
    output logic              busy,
    output logic              done
);

    localparam int            TW         = CW + LOG2_N;
    localparam logic [CW-1:0] LAST_CYCLE = '1;
    localparam logic [SW-1:0] LAST_STAGE = SW'(LOG2_N - 1);
    localparam logic [3:0]    GAP_LAST   = 4'(STAGE_GAP - 1);

    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

    state_t        state, nState;
    logic [SW-1:0] stageR, nStage;
    logic [CW-1:0] cycleR, nCycle;
    logic [3:0]    gapCnt, nGap;
    logic          nRun;
    logic [LOG2_N-1:0] nIndexA, nIndexB;
    logic [CW-1:0]     nTwiddle;

    // Upper-leg address: cycle with a zero inserted at bit p = LOG2_N-1-stage.
    function automatic logic [LOG2_N-1:0] calcIndexA(input logic [SW-1:0] s, input logic [CW-1:0] c);
        int p;
        logic [LOG2_N-1:0] wide, lowMask;
        p       = LOG2_N - 1 - int'(s);
        wide    = LOG2_N'(c);
        lowMask = (LOG2_N'(1) << p) - LOG2_N'(1);
        return ((wide >> p) << (p + 1)) | (wide & lowMask);
    endfunction

    function automatic logic [LOG2_N-1:0] calcIndexB(input logic [SW-1:0] s, input logic [LOG2_N-1:0] a);
        return a | (LOG2_N'(1) << (LOG2_N - 1 - int'(s)));
    endfunction

    function automatic logic [CW-1:0] calcTwiddle(input logic [SW-1:0] s, input logic [CW-1:0] c);
        logic [TW-1:0] wide;
        logic [CW-1:0] raw, rev;
        wide = TW'(c) << (int'(s) + 1);
        raw  = CW'(wide >> LOG2_N);
        for (int i = 0; i < CW; i++) rev[i] = raw[CW-1-i];
        return rev;
    endfunction

    always_comb begin
        nState = state;
        nStage = stageR;
        nCycle = cycleR;
        nGap   = gapCnt;
        case (state)
            IDLE: if (start) begin
                nState = RUN;
                nStage = '0;
                nCycle = '0;
            end
            RUN: if (out_ready) begin
                if (cycleR != LAST_CYCLE) begin
                    nCycle = cycleR + CW'(1);
                end else if (stageR != LAST_STAGE) begin
                    nStage = stageR + SW'(1);
                    nCycle = '0;
                    nGap   = '0;
                    nState = (STAGE_GAP > 0) ? GAP : RUN;
                end else begin
                    nState = DONE;
                end
            end
            GAP: if (gapCnt == GAP_LAST) nState = RUN;
                 else nGap = gapCnt + 4'd1;
            DONE: nState = IDLE;
        endcase
        nRun     = (nState == RUN);
        nIndexA  = calcIndexA(nStage, nCycle);
        nIndexB  = calcIndexB(nStage, nIndexA);
        nTwiddle = calcTwiddle(nStage, nCycle);
    end

    // NOTE: outputs are registered from the next-state values, so a stalled beat
    // recomputes from unchanged stage/cycle and holds without a separate hold path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            stageR       <= '0;
            cycleR       <= '0;
            gapCnt       <= '0;
            out_valid    <= 1'b0;
            indexA       <= '0;
            indexB       <= '0;
            twiddleIndex <= '0;
            twiddleConj  <= 1'b0;
            stage        <= '0;
            lastBeat     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= nState;
            stageR       <= nStage;
            cycleR       <= nCycle;
            gapCnt       <= nGap;
            if (state == IDLE && start) twiddleConj <= inverse;
            out_valid    <= nRun;
            indexA       <= nRun ? nIndexA  : '0;
            indexB       <= nRun ? nIndexB  : '0;
            twiddleIndex <= nRun ? nTwiddle : '0;
            stage        <= nRun ? nStage   : '0;
            lastBeat     <= nRun && (nStage == LAST_STAGE) && (nCycle == LAST_CYCLE);
            busy         <= (nState == RUN) || (nState == GAP);
            done         <= (nState == DONE);
        end
    end

endmodule

// File: tb/tb_fft_addr_sequencer.sv
// Self-checking bench for fft_addr_sequencer: default 1024-point instance plus an 8-point, gap-free instance.
module tb_fft_addr_sequencer;

    localparam int LN  = 10;
    localparam int GAP = 2;
    localparam int N   = 1 << LN;
    localparam int CW  = LN - 1;
    localparam int SW  = $clog2(LN);
    localparam int LN8 = 3;
    localparam int CW8 = LN8 - 1;
    localparam int SW8 = $clog2(LN8);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, inverse, outReady;
    logic          outValid, twiddleConj, lastBeat, busy, done;
    logic [LN-1:0] indexA, indexB;
    logic [CW-1:0] twiddleIndex;
    logic [SW-1:0] stage;

    logic           rst8, start8, inverse8, ready8;
    logic           valid8, conj8, last8, busy8, done8;
    logic [LN8-1:0] a8, b8;
    logic [CW8-1:0] tw8;
    logic [SW8-1:0] stage8;

    fft_addr_sequencer #(.LOG2_N(LN), .STAGE_GAP(GAP)) dut (
        .clk(clk), .rst(rst), .start(start), .inverse(inverse), .out_ready(outReady),
        .out_valid(outValid), .indexA(indexA), .indexB(indexB), .twiddleIndex(twiddleIndex),
        .twiddleConj(twiddleConj), .stage(stage), .lastBeat(lastBeat), .busy(busy), .done(done)
    );

    fft_addr_sequencer #(.LOG2_N(LN8), .STAGE_GAP(0)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .inverse(inverse8), .out_ready(ready8),
        .out_valid(valid8), .indexA(a8), .indexB(b8), .twiddleIndex(tw8),
        .twiddleConj(conj8), .stage(stage8), .lastBeat(last8), .busy(busy8), .done(done8)
    );

    logic [34:0] outBus;
    assign outBus = {indexA, indexB, twiddleIndex, stage, lastBeat, twiddleConj};

    typedef struct {int stg; int a; int b; int tw; bit last;} beat_t;
    beat_t expQ[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int bitrev(input int v, input int w);
        int r = 0;
        for (int i = 0; i < w; i++) r |= ((v >> i) & 1) << (w - 1 - i);
        return r;
    endfunction

    // Reference order: per stage, butterfly groups of span N/2>>s, legs span apart.
    task automatic loadModel(input int logN);
        int n;
        beat_t bt;
        n = 1 << logN;
        expQ.delete();
        for (int s = 0; s < logN; s++) begin
            int span;
            span = (n / 2) >> s;
            for (int g = 0; g < n; g += 2 * span)
                for (int k = 0; k < span; k++) begin
                    bt.stg  = s;
                    bt.a    = g + k;
                    bt.b    = g + k + span;
                    bt.tw   = bitrev(g / (2 * span), logN - 1);
                    bt.last = (s == logN - 1) && (g + 2 * span >= n) && (k == span - 1);
                    expQ.push_back(bt);
                end
        end
    endtask

    task automatic scoreBeat(input string tag, input int stg, input int a, input int b,
                             input int tw, input logic last);
        beat_t e;
        check({tag, " beat expected"}, 64'(expQ.size() > 0), 64'd1);
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check({tag, " stage"}, 64'(stg), 64'(e.stg));
            check({tag, " indexA"}, 64'(a), 64'(e.a));
            check({tag, " indexB"}, 64'(b), 64'(e.b));
            check({tag, " twiddle"}, 64'(tw), 64'(e.tw));
            check({tag, " lastBeat"}, 64'(last), 64'(e.last));
        end
    endtask

    task automatic runDefault(input string tag, input int readyPct, input bit toggleInv, input bit expInv);
        int cyc, beats, lowRun, gaps, lastCnt, doneCyc, firstCyc;
        bit holdPend;
        logic [34:0] snap;
        loadModel(LN);
        beats = 0; lowRun = 0; gaps = 0; lastCnt = 0; doneCyc = 0; firstCyc = 0;
        holdPend = 1'b0; snap = '0;
        @(negedge clk);
        inverse = expInv;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (cyc < 30000 && doneCyc == 0) begin
            outReady = (readyPct >= 100) ? 1'b1 : ($urandom_range(99) < readyPct);
            if (toggleInv) inverse = 1'($urandom);
            if (holdPend) check({tag, " hold stable"}, 64'(outBus), 64'(snap));
            if (outValid) begin
                if (firstCyc == 0) firstCyc = cyc;
                if (lowRun > 0) begin
                    check({tag, " gap length"}, 64'(lowRun), 64'(GAP));
                    gaps++;
                    lowRun = 0;
                end
                check({tag, " twiddleConj"}, 64'(twiddleConj), 64'(expInv));
                if (outReady) begin
                    scoreBeat(tag, int'(stage), int'(indexA), int'(indexB), int'(twiddleIndex), lastBeat);
                    beats++;
                end
            end else if (busy) begin
                lowRun++;
                check({tag, " idle outputs zero"}, 64'({indexA, indexB, twiddleIndex, stage, lastBeat}), 64'd0);
            end
            if (lastBeat) lastCnt++;
            if (done) doneCyc = cyc;
            holdPend = outValid && !outReady;
            snap     = outBus;
            @(negedge clk);
            cyc++;
        end
        check({tag, " done seen"}, 64'(doneCyc > 0), 64'd1);
        check({tag, " first beat latency"}, 64'(firstCyc), 64'd1);
        if (readyPct >= 100) check({tag, " done cycle"}, 64'(doneCyc), 64'(LN * N / 2 + (LN - 1) * GAP + 1));
        check({tag, " accepted beats"}, 64'(beats), 64'(LN * N / 2));
        check({tag, " queue drained"}, 64'(expQ.size()), 64'd0);
        check({tag, " lastBeat count"}, 64'(lastCnt), 64'd1);
        check({tag, " stage gaps"}, 64'(gaps), 64'(LN - 1));
        check({tag, " done single pulse"}, 64'(done), 64'd0);
        check({tag, " busy after done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int cyc, beats, doneCyc, waited;
        rst = 1'b1; start = 1'b0; inverse = 1'b0; outReady = 1'b0;
        rst8 = 1'b1; start8 = 1'b0; inverse8 = 1'b0; ready8 = 1'b0;
        repeat (2) @(negedge clk);
        check("reset valid", 64'(outValid), 64'd0);
        check("reset busy/done", 64'({busy, done}), 64'd0);
        check("reset outputs", 64'(outBus), 64'd0);
        check("reset n8 valid/busy", 64'({valid8, busy8, done8}), 64'd0);
        rst = 1'b0; rst8 = 1'b0;
        outReady = 1'b1;

        runDefault("full", 100, 1'b0, 1'b0);
        runDefault("rand", 50, 1'b1, 1'b1);

        // 8-point, no gaps; a second start mid-run must be ignored.
        loadModel(LN8);
        ready8 = 1'b1;
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 1; beats = 0; doneCyc = 0;
        while (cyc < 40 && doneCyc == 0) begin
            start8 = (cyc == 5);
            if (cyc <= 12) check("n8 back-to-back valid", 64'(valid8), 64'd1);
            if (valid8 && ready8) begin
                scoreBeat("n8", int'(stage8), int'(a8), int'(b8), int'(tw8), last8);
                beats++;
            end
            if (done8) doneCyc = cyc;
            @(negedge clk);
            cyc++;
        end
        start8 = 1'b0;
        check("n8 beats", 64'(beats), 64'd12);
        check("n8 done cycle", 64'(doneCyc), 64'd13);
        check("n8 queue drained", 64'(expQ.size()), 64'd0);
        repeat (3) @(negedge clk);
        check("n8 no restart", 64'({valid8, busy8}), 64'd0);

        // Reset in the middle of stage 4 abandons the transform.
        outReady = 1'b1;
        inverse  = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!(outValid && stage == SW'(4)) && waited < 4000) begin
            @(negedge clk);
            waited++;
        end
        check("reach stage 4", 64'(waited < 4000), 64'd1);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        inverse = 1'b0;
        check("midreset valid/busy/done", 64'({outValid, busy, done}), 64'd0);
        check("midreset outputs", 64'(outBus), 64'd0);
        doneCyc = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) doneCyc++;
        end
        check("midreset no done", 64'(doneCyc), 64'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart valid", 64'(outValid), 64'd1);
        check("restart beat", 64'({stage, indexA, indexB, twiddleIndex}), 64'({SW'(0), LN'(0), LN'(N / 2), CW'(0)}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_addr_sequencer.md
Name: fft_addr_sequencer

Overview:
Sequential, parametrised address/twiddle sequencer for the in-place radix-2 FFT engine. One start pulse walks every butterfly of every stage and issues a valid/ready stream of {indexA, indexB, twiddleIndex} to the butterfly datapath. It generalises the fixed 1024-point combinational generator: any power-of-two size, inverse-transform mode, programmable inter-stage drain bubbles, backpressure, and a done pulse for the FFT control FSM.

Parameters:
LOG2_N, 10, log2 of FFT size; N = 2**LOG2_N; legal 3..12
STAGE_GAP, 2, idle cycles with valid low between the last accepted beat of a stage and the first beat of the next stage; covers butterfly pipeline depth; legal 0..15
Local: CW = LOG2_N-1 (cycle/twiddle width); SW = $clog2(LOG2_N) (stage width)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a transform; honoured only in IDLE
inverse  in  1  IFFT select; sampled on accepted start and held internally
out_ready  in  1  butterfly datapath can accept the current beat
out_valid  out  1  beat on outputs is valid
indexA  out  LOG2_N  upper-leg sample address
indexB  out  LOG2_N  lower-leg sample address
twiddleIndex  out  CW  bit-reversed twiddle ROM index
twiddleConj  out  1  conjugate the twiddle (= latched inverse)
stage  out  SW  stage of current beat
lastBeat  out  1  current beat is the final beat of the transform
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; ports named clk and rst.
- Reset (synchronous, dominates everything, including mid-transform): state=IDLE; all outputs 0; internal stage, cycle, gap counters 0; latched inverse 0. Any in-flight transform is abandoned with no done pulse.
- FSM states: IDLE, RUN, GAP, DONE.
- IDLE: start=1 latches inverse, clears stage and cycle, enters RUN. The first beat is on the outputs with out_valid=1 on the next cycle (1-cycle latency). busy=1 from that cycle.
- RUN: out_valid=1. A beat is accepted when out_valid && out_ready. Every output is held stable while out_valid && !out_ready.
- On accept with cycle<N/2-1: cycle++.
- On accept with cycle=N/2-1 and stage<LOG2_N-1: stage++, cycle=0. Enter GAP if STAGE_GAP>0; otherwise stay in RUN, with the next beat presented immediately.
- On accept with cycle=N/2-1 and stage=LOG2_N-1: enter DONE.
- GAP: out_valid=0 for exactly STAGE_GAP cycles, then RUN. out_ready is ignored.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- start outside IDLE is ignored. start in the DONE cycle is ignored; it is accepted only from IDLE.
- Address rule, with p = LOG2_N-1-stage:
  - indexA = cycle with a 0 inserted at bit p (bits above p shift up by one).
  - indexB = indexA | (1<<p).
  - Equivalently, indexB = indexA + (N/2 >> stage).
- Twiddle rule:
  - raw = ((cycle << (stage+1)) >> LOG2_N), truncated to CW bits; compute at width CW+LOG2_N with no overflow.
  - twiddleIndex = raw bit-reversed over CW bits.
  - twiddleConj = latched inverse. It is constant for the whole transform; a change on the inverse input mid-transform has no effect.
- lastBeat=1 exactly when stage=LOG2_N-1 and cycle=N/2-1 and out_valid=1.
- All outputs are registered; no combinational path from out_ready to outputs other than through the hold rule.
- Total accepted beats per transform = LOG2_N*N/2.
- With out_ready tied high, latency from start to done = LOG2_N*N/2 + (LOG2_N-1)*STAGE_GAP + 1 cycles after start's cycle + 1.
- When out_valid=0 (IDLE/GAP/DONE), address, twiddle, stage and lastBeat outputs are 0.

Test Plan:
- Defaults, rst for 2 cycles then start at cycle t, out_ready=1 -> out_valid first at t+1 with indexA=0, indexB=512, twiddleIndex=0, stage=0. Stage 0, cycle 5 -> indexA=5, indexB=517, twiddleIndex=0.
- Stage 1, cycle 300 -> indexA=556, indexB=812, twiddleIndex=256. Stage 9, cycle 3 -> indexA=6, indexB=7, twiddleIndex=384, and lastBeat=0 until cycle 511.
- Full run, defaults, out_ready=1 -> exactly 5120 accepted beats. out_valid low for exactly 2 cycles at each of 9 stage boundaries. lastBeat on one beat only. done single pulse at t+5139. busy low afterwards.
- Randomised out_ready (~50%) -> outputs stable whenever valid && !ready. Every (stage, cycle) pair issued exactly once, in order. inverse=1 at start -> twiddleConj=1 throughout even if inverse toggles mid-run.
- LOG2_N=3, STAGE_GAP=0 -> 12 beats back-to-back. Stage 2 pairs are (0,1),(2,3),(4,5),(6,7). Second start mid-run is ignored.
- rst asserted mid-stage 4 -> next cycle all outputs 0, no done. A fresh start then restarts at stage 0, cycle 0.
